ram8_arbiter: RTL and testbench

Two-requester round-robin arbiter and initialiser for the eight-register RAM (8 × 16-bit, 3-bit address, `load`-qualified write on `clk`, combinational `out` of the addressed word). After reset, and on a `clear` pulse, it writes zero to all eight locations. Otherwise it grants one single-word read or write per cycle to requester 0 or 1 over a req/ack handshake. It sits between the CPU-side and debug-side masters and the single shared RAM instance.

---
 rtl/ram8_arbiter.sv | 113 +++++++++++
 tb/tb_ram8_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram8_arbiter.sv
// ram8_arbiter: two-requester round-robin arbiter and zero-fill initialiser for an 8 x WIDTH register RAM.
// Ports: clk, reset (async, active-high), clear (zero-fill request); per requester N: reqN/weN/addrN/wdataN in,
//        ackN/rdataN out; busy during fill; ram_in/ram_load/ram_address drive the RAM, ram_out is its read port.
// Latency: grant in the first eligible cycle, ack and read data one cycle later; requests wait while busy.
module ram8_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             req0,
  input  logic             we0,
  input  logic [2:0]       addr0,
  input  logic [WIDTH-1:0] wdata0,
  input  logic             req1,
  input  logic             we1,
  input  logic [2:0]       addr1,
  input  logic [WIDTH-1:0] wdata1,
  output logic             ack0,
  output logic [WIDTH-1:0] rdata0,
  output logic             ack1,
  output logic [WIDTH-1:0] rdata1,
  output logic             busy,
  output logic [WIDTH-1:0] ram_in,
  output logic             ram_load,
  output logic [2:0]       ram_address,
  input  logic [WIDTH-1:0] ram_out
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0] state;
  logic [2:0] cnt;
  logic       last;     // previous winner; the other requester wins a tie
  logic       run_ok;
  logic       elig0;
  logic       elig1;
  logic       grant0;
  logic       grant1;

  assign busy   = (state == ST_INIT);
  // A clear sampled in RUN starts the fill and suppresses any grant in that cycle.
  assign run_ok = (state == ST_RUN) && !clear;

  // The ack cycle masks the request that is still held (or already replaced)
  // by the requester, so each requester gets at most one grant per two cycles.
  assign elig0  = req0 && !ack0;
  assign elig1  = req1 && !ack1;

  assign grant0 = run_ok && elig0 && (!elig1 || last);
  assign grant1 = run_ok && elig1 && (!elig0 || !last);

  // RAM port mux: fill counter during INIT, otherwise the winner (or idle zeros).
  always_comb begin
    ram_load    = 1'b0;
    ram_address = 3'd0;
    ram_in      = '0;
    if (state == ST_INIT) begin
      ram_load    = 1'b1;
      ram_address = cnt;
    end else if (grant0) begin
      ram_load    = we0;
      ram_address = addr0;
      ram_in      = wdata0;
    end else if (grant1) begin
      ram_load    = we1;
      ram_address = addr1;
      ram_in      = wdata1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_INIT;
      cnt    <= 3'd0;
      last   <= 1'b1;
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      ack0 <= grant0;
      ack1 <= grant1;

      if (grant0) begin
        last <= 1'b0;
      end else if (grant1) begin
        last <= 1'b1;
      end

      // ram_out is the combinational read of the granted address; a write
      // grant leaves the requester's read data untouched.
      if (grant0 && !we0) begin
        rdata0 <= ram_out;
      end
      if (grant1 && !we1) begin
        rdata1 <= ram_out;
      end

      if (state == ST_INIT) begin
        cnt <= cnt + 3'd1;
        if (cnt == 3'd7) begin
          state <= ST_RUN;
        end
      end else if (clear) begin
        state <= ST_INIT;
        cnt   <= 3'd0;
      end
    end
  end

endmodule

// File: tb/tb_ram8_arbiter.sv
// tb_ram8_arbiter: bench for ram8_arbiter with a behavioural 8-word RAM attached to its ram_* port.
// Directed vector table plus hand-written fill/clear/reset sequences, then randomized traffic
// compared against a transaction-level reference model.
module tb_ram8_arbiter;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         clear;
  logic         req0, we0, req1, we1;
  logic [2:0]   addr0, addr1;
  logic [W-1:0] wdata0, wdata1;
  logic         ack0, ack1, busy, ram_load;
  logic [W-1:0] rdata0, rdata1, ram_in, ram_out;
  logic [2:0]   ram_address;

  logic [W-1:0] ram [8];

  int checks   = 0;
  int failures = 0;

  ram8_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0), .rdata0(rdata0), .ack1(ack1), .rdata1(rdata1),
    .busy(busy), .ram_in(ram_in), .ram_load(ram_load),
    .ram_address(ram_address), .ram_out(ram_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_load) ram[ram_address] <= ram_in;
  end
  assign ram_out = ram[ram_address];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Move to just after the next rising edge, where inputs are driven.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
  endtask

  // Starts just after the edge opening fill cycle 0; ends at the falling edge of
  // cycle 8 with busy low. clear is pulsed in fill cycle pulse_at (it must be ignored).
  task automatic check_fill(input string tag, input int pulse_at);
    for (int i = 0; i < 8; i++) begin
      clear = (i == pulse_at);
      @(negedge clk);
      chk($sformatf("%s fill%0d busy", tag, i), busy, 1);
      chk($sformatf("%s fill%0d addr", tag, i), ram_address, i);
      chk($sformatf("%s fill%0d load", tag, i), ram_load, 1);
      chk($sformatf("%s fill%0d in", tag, i), ram_in, 0);
      chk($sformatf("%s fill%0d ack0", tag, i), ack0, 0);
      chk($sformatf("%s fill%0d ack1", tag, i), ack1, 0);
      step();
    end
    clear = 0;
    @(negedge clk);
    chk({tag, " busy after fill"}, busy, 0);
  endtask

  typedef struct packed {
    logic        r0, w0; logic [2:0] a0; logic [15:0] d0;
    logic        r1, w1; logic [2:0] a1; logic [15:0] d1;
    logic        k0, k1, ld; logic [2:0] ad; logic [15:0] di;
    logic        c0; logic [15:0] q0;
    logic        c1; logic [15:0] q1;
  } vec_t;

  function automatic vec_t mk(
    input logic r0, input logic w0, input logic [2:0] a0, input logic [15:0] d0,
    input logic r1, input logic w1, input logic [2:0] a1, input logic [15:0] d1,
    input logic k0, input logic k1, input logic ld, input logic [2:0] ad, input logic [15:0] di,
    input logic c0, input logic [15:0] q0, input logic c1, input logic [15:0] q1);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.k0 = k0; v.k1 = k1; v.ld = ld; v.ad = ad; v.di = di;
    v.c0 = c0; v.q0 = q0; v.c1 = c1; v.q1 = q1;
    return v;
  endfunction

  localparam int NV = 17;
  vec_t tbl [NV];

  // Reference model state (random phase)
  logic [15:0] m_mem [8];
  logic [15:0] m_rd  [2];
  bit          m_ack [2];
  int          m_last;
  int          m_fill;
  bit          h_req [2];
  bit          h_we  [2];
  logic [2:0]  h_addr[2];
  logic [15:0] h_dat [2];

  initial begin
    //           r0 w0 a0  d0        r1 w1 a1  d1        k0 k1 ld ad  in        c0 q0        c1 q1
    // Both requesting continuously: grants 0,1,0,1,0,1
    tbl[0]  = mk(1, 0, 2, 16'h0000, 1, 1, 7, 16'haaaa, 0, 0, 0, 2, 16'h0000, 0, 16'h0000, 1, 16'h0000);
    tbl[1]  = mk(1, 0, 2, 16'h0000, 1, 1, 7, 16'haaaa, 1, 0, 1, 7, 16'haaaa, 1, 16'h0000, 0, 16'h0000);
    tbl[2]  = mk(1, 0, 2, 16'h0000, 1, 1, 7, 16'haaaa, 0, 1, 0, 2, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    tbl[3]  = mk(1, 0, 2, 16'h0000, 1, 1, 7, 16'haaaa, 1, 0, 1, 7, 16'haaaa, 0, 16'h0000, 0, 16'h0000);
    tbl[4]  = mk(1, 0, 2, 16'h0000, 1, 1, 7, 16'haaaa, 0, 1, 0, 2, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    tbl[5]  = mk(1, 0, 2, 16'h0000, 1, 1, 7, 16'haaaa, 1, 0, 1, 7, 16'haaaa, 0, 16'h0000, 0, 16'h0000);
    tbl[6]  = mk(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    // req1 writes b123 to 4, req0 reads it back next
    tbl[7]  = mk(0, 0, 0, 16'h0000, 1, 1, 4, 16'hb123, 0, 0, 1, 4, 16'hb123, 0, 16'h0000, 1, 16'h0000);
    tbl[8]  = mk(1, 0, 4, 16'h0000, 0, 0, 0, 16'h0000, 0, 1, 0, 4, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    tbl[9]  = mk(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 1, 16'hb123, 1, 16'h0000);
    // req0 writes 1234 to 5; read presented in the ack cycle is masked until the next cycle
    tbl[10] = mk(1, 1, 5, 16'h1234, 0, 0, 0, 16'h0000, 0, 0, 1, 5, 16'h1234, 0, 16'h0000, 0, 16'h0000);
    tbl[11] = mk(1, 0, 5, 16'h5555, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    tbl[12] = mk(1, 0, 5, 16'h5555, 0, 0, 0, 16'h0000, 0, 0, 0, 5, 16'h5555, 1, 16'hb123, 0, 16'h0000);
    tbl[13] = mk(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 1, 16'h1234, 0, 16'h0000);
    // Tie with last winner 0: requester 1 first
    tbl[14] = mk(1, 0, 5, 16'h0000, 1, 0, 7, 16'h0000, 0, 0, 0, 7, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    tbl[15] = mk(1, 0, 5, 16'h0000, 0, 0, 0, 16'h0000, 0, 1, 0, 5, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    tbl[16] = mk(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 1, 16'h1234, 1, 16'haaaa);

    reset = 1; clear = 0;
    idle_inputs();

    // ---------------- reset state and initial fill ----------------
    @(posedge clk);
    @(negedge clk);
    chk("rst busy", busy, 1);
    chk("rst ack0", ack0, 0);
    chk("rst ack1", ack1, 0);
    chk("rst rdata0", rdata0, 0);
    chk("rst rdata1", rdata1, 0);
    chk("rst load", ram_load, 1);
    chk("rst addr", ram_address, 0);
    chk("rst in", ram_in, 0);
    step();
    reset = 0;
    check_fill("init", -1);
    step();

    // Every word reads zero after the fill (via requester 1, keeping last = 1)
    for (int a = 0; a < 8; a++) begin
      req1 = 1; we1 = 0; addr1 = 3'(a);
      @(negedge clk);
      chk($sformatf("rd0s addr%0d", a), ram_address, a);
      step();
      req1 = 0;
      @(negedge clk);
      chk($sformatf("rd0s ack1 %0d", a), ack1, 1);
      chk($sformatf("rd0s rdata1 %0d", a), rdata1, 0);
      step();
    end

    // ---------------- vector table ----------------
    for (int i = 0; i < NV; i++) begin
      req0 = tbl[i].r0; we0 = tbl[i].w0; addr0 = tbl[i].a0; wdata0 = tbl[i].d0;
      req1 = tbl[i].r1; we1 = tbl[i].w1; addr1 = tbl[i].a1; wdata1 = tbl[i].d1;
      @(negedge clk);
      chk($sformatf("v%0d ack0", i), ack0, tbl[i].k0);
      chk($sformatf("v%0d ack1", i), ack1, tbl[i].k1);
      chk($sformatf("v%0d load", i), ram_load, tbl[i].ld);
      chk($sformatf("v%0d addr", i), ram_address, tbl[i].ad);
      chk($sformatf("v%0d in", i), ram_in, tbl[i].di);
      chk($sformatf("v%0d busy", i), busy, 0);
      if (tbl[i].c0) chk($sformatf("v%0d rdata0", i), rdata0, tbl[i].q0);
      if (tbl[i].c1) chk($sformatf("v%0d rdata1", i), rdata1, tbl[i].q1);
      step();
    end
    idle_inputs();

    // ---------------- clear in RUN with req0 pending ----------------
    req0 = 1; we0 = 0; addr0 = 5; clear = 1;
    @(negedge clk);
    chk("clr busy0", busy, 0);
    chk("clr no grant load", ram_load, 0);
    chk("clr no grant addr", ram_address, 0);
    step();
    clear = 0;
    check_fill("clr", 3);
    chk("clr grant addr", ram_address, 5);
    chk("clr grant load", ram_load, 0);
    step();
    req0 = 0;
    @(negedge clk);
    chk("clr ack0", ack0, 1);
    chk("clr rdata0", rdata0, 0);
    step();

    // ---------------- put 3c3c at address 3, read it back ----------------
    req0 = 1; we0 = 1; addr0 = 3; wdata0 = 16'h3c3c;
    @(negedge clk);
    chk("pre wr load", ram_load, 1);
    step();
    we0 = 0; wdata0 = 0;
    @(negedge clk);
    chk("pre wr ack0", ack0, 1);
    step();
    @(negedge clk);
    chk("pre rd addr", ram_address, 3);
    step();
    req0 = 0;
    @(negedge clk);
    chk("pre rd rdata0", rdata0, 16'h3c3c);
    step();

    // ---------------- reset in the grant cycle of a req1 write ----------------
    req1 = 1; we1 = 1; addr1 = 3; wdata1 = 16'hffff;
    @(negedge clk);
    chk("rg grant load", ram_load, 1);
    chk("rg grant addr", ram_address, 3);
    chk("rg grant in", ram_in, 16'hffff);
    #1 reset = 1;
    #1;
    chk("rg busy", busy, 1);
    chk("rg addr", ram_address, 0);
    chk("rg in", ram_in, 0);
    chk("rg rdata0", rdata0, 0);
    chk("rg rdata1", rdata1, 0);
    step();
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    @(negedge clk);
    chk("rg no ack1", ack1, 0);
    step();
    reset = 0;
    check_fill("rg", -1);
    step();
    req0 = 1; we0 = 0; addr0 = 3;
    @(negedge clk);
    chk("rg rd addr", ram_address, 3);
    step();
    req0 = 0;
    @(negedge clk);
    chk("rg rd ack0", ack0, 1);
    chk("rg rd rdata0", rdata0, 0);
    step();

    // ---------------- randomized traffic vs reference model ----------------
    reset = 1;
    idle_inputs();
    step();
    step();
    reset = 0;
    for (int i = 0; i < 8; i++) m_mem[i] = 0;
    for (int n = 0; n < 2; n++) begin
      m_rd[n] = 0; m_ack[n] = 0; h_req[n] = 0; h_we[n] = 0; h_addr[n] = 0; h_dat[n] = 0;
    end
    m_last = 1;
    m_fill = 8;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      int          win;
      bit          clr, e_load, n_ack0, n_ack1;
      logic [2:0]  e_addr;
      logic [15:0] e_in;

      // Requesters: hold until ack, then maybe present a new transaction.
      for (int n = 0; n < 2; n++) begin
        if (!h_req[n] || m_ack[n]) begin
          h_req[n] = ($urandom_range(0, 9) < 6);
          h_we[n]  = 1'($urandom_range(0, 1));
          h_addr[n] = 3'($urandom_range(0, 7));
          h_dat[n] = 16'($urandom);
        end
      end
      clr = ($urandom_range(0, 149) == 0);
      req0 = h_req[0]; we0 = h_we[0]; addr0 = h_addr[0]; wdata0 = h_dat[0];
      req1 = h_req[1]; we1 = h_we[1]; addr1 = h_addr[1]; wdata1 = h_dat[1];
      clear = clr;

      win = -1; e_load = 0; e_addr = 0; e_in = 0;
      if (m_fill > 0) begin
        e_load = 1; e_addr = 3'(8 - m_fill);
      end else if (!clr) begin
        bit c0, c1;
        c0 = h_req[0] && !m_ack[0];
        c1 = h_req[1] && !m_ack[1];
        if (c0 && c1) win = (m_last == 0) ? 1 : 0;
        else if (c0) win = 0;
        else if (c1) win = 1;
        if (win >= 0) begin
          e_load = h_we[win]; e_addr = h_addr[win]; e_in = h_dat[win];
        end
      end

      @(negedge clk);
      chk($sformatf("rnd%0d busy", cyc), busy, (m_fill > 0));
      chk($sformatf("rnd%0d ack0", cyc), ack0, m_ack[0]);
      chk($sformatf("rnd%0d ack1", cyc), ack1, m_ack[1]);
      chk($sformatf("rnd%0d rdata0", cyc), rdata0, m_rd[0]);
      chk($sformatf("rnd%0d rdata1", cyc), rdata1, m_rd[1]);
      chk($sformatf("rnd%0d load", cyc), ram_load, e_load);
      chk($sformatf("rnd%0d addr", cyc), ram_address, e_addr);
      chk($sformatf("rnd%0d in", cyc), ram_in, e_in);

      n_ack0 = 0; n_ack1 = 0;
      if (m_fill > 0) begin
        m_mem[8 - m_fill] = 0;
        m_fill--;
      end else if (clr) begin
        m_fill = 8;
      end else if (win >= 0) begin
        if (h_we[win]) m_mem[h_addr[win]] = h_dat[win];
        else m_rd[win] = m_mem[h_addr[win]];
        m_last = win;
        if (win == 0) n_ack0 = 1; else n_ack1 = 1;
      end
      m_ack[0] = n_ack0;
      m_ack[1] = n_ack1;
      step();
    end

    clear = 0;
    idle_inputs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
